// File: rtl/commit_trace_gen.sv
// commit_trace_gen
//   Producer side of the commit-trace interface consumed by the ISA-test
//   scoreboard. Four tag registers (D=IF/ID, E=ID/EX, M=EX/MEM, W=MEM/WB)
//   follow the 5-stage pipeline. Each tag carries {vld, pc, ctrl, mispred}.
//   The W tag drives the commit record directly. Saturating performance
//   counters accumulate cycles, committed instructions, committed control
//   ops and committed mispredicts.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_if_pc        pc fetched this cycle
//   i_if_vld       fetch slot holds a real instruction
//   i_stall        load-use stall: hold IF/ID, bubble into ID/EX
//   i_flush        EX-resolved redirect: kill IF/ID and ID/EX
//   i_ex_ctrl      instruction in EX is a branch/jump
//   i_ex_mispred   instruction in EX was mispredicted
//   i_cnt_clr      synchronous clear of all counters
//   o_pc_debug     pc of WB slot
//   o_insn_vld     WB slot is a committed instruction
//   o_ctrl         committed instruction is control-flow
//   o_mispred      committed instruction was mispredicted
//   o_cnt_cycle    cycles since reset/clear
//   o_cnt_insn     committed instructions
//   o_cnt_ctrl     committed control-flow instructions
//   o_cnt_mispred  committed mispredicts
module commit_trace_gen #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_if_pc,
  input  logic             i_if_vld,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_ex_ctrl,
  input  logic             i_ex_mispred,
  input  logic             i_cnt_clr,
  output logic [31:0]      o_pc_debug,
  output logic             o_insn_vld,
  output logic             o_ctrl,
  output logic             o_mispred,
  output logic [CNT_W-1:0] o_cnt_cycle,
  output logic [CNT_W-1:0] o_cnt_insn,
  output logic [CNT_W-1:0] o_cnt_ctrl,
  output logic [CNT_W-1:0] o_cnt_mispred
);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        ctrl;
    logic        mispred;
  } tag_t;

  localparam tag_t TAG_RST = '{vld: 1'b0, pc: RESET_PC, ctrl: 1'b0, mispred: 1'b0};

  tag_t d_q, d_d;
  tag_t e_q, e_d;
  tag_t m_q, m_d;
  tag_t w_q, w_d;

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] insn_q, insn_d;
  logic [CNT_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] misp_q, misp_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Tag pipeline next state. Flush and stall only reach D and E; the EX
  // instruction that raised the flush still moves on to M with its outcome.
  always_comb begin
    d_d = d_q;
    e_d = d_q;
    m_d = e_q;
    w_d = m_q;

    if (i_flush) begin
      d_d = '{vld: 1'b0, pc: i_if_pc, ctrl: 1'b0, mispred: 1'b0};
    end else if (!i_stall) begin
      d_d = '{vld: i_if_vld, pc: i_if_pc, ctrl: 1'b0, mispred: 1'b0};
    end

    // Bubbles keep the pc of the slot they replace so halts stay visible.
    if (i_flush || i_stall) begin
      e_d.vld = 1'b0;
    end

    // Outcome is tagged only onto a real instruction; mispred needs ctrl.
    m_d.ctrl    = e_q.vld & i_ex_ctrl;
    m_d.mispred = e_q.vld & i_ex_ctrl & i_ex_mispred;
  end

  // Counters sample the W tag currently on the outputs.
  always_comb begin
    cyc_d  = sat_inc(cyc_q, 1'b1);
    insn_d = sat_inc(insn_q, w_q.vld);
    ctrl_d = sat_inc(ctrl_q, w_q.ctrl);
    misp_d = sat_inc(misp_q, w_q.mispred);
    if (i_cnt_clr) begin
      cyc_d  = '0;
      insn_d = '0;
      ctrl_d = '0;
      misp_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      d_q    <= TAG_RST;
      e_q    <= TAG_RST;
      m_q    <= TAG_RST;
      w_q    <= TAG_RST;
      cyc_q  <= '0;
      insn_q <= '0;
      ctrl_q <= '0;
      misp_q <= '0;
    end else begin
      d_q    <= d_d;
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      cyc_q  <= cyc_d;
      insn_q <= insn_d;
      ctrl_q <= ctrl_d;
      misp_q <= misp_d;
    end
  end

  assign o_pc_debug    = w_q.pc;
  assign o_insn_vld    = w_q.vld;
  assign o_ctrl        = w_q.ctrl;
  assign o_mispred     = w_q.mispred;
  assign o_cnt_cycle   = cyc_q;
  assign o_cnt_insn    = insn_q;
  assign o_cnt_ctrl    = ctrl_q;
  assign o_cnt_mispred = misp_q;

endmodule

// File: tb/tb_commit_trace_gen.sv
// Directed testbench for commit_trace_gen. Two instances share stimulus:
// a full-width one and a CNT_W=4 one for counter saturation.
module tb_commit_trace_gen;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_if_pc;
  logic        i_if_vld;
  logic        i_stall;
  logic        i_flush;
  logic        i_ex_ctrl;
  logic        i_ex_mispred;
  logic        i_cnt_clr;

  logic [31:0] o_pc_debug;
  logic        o_insn_vld, o_ctrl, o_mispred;
  logic [31:0] o_cnt_cycle, o_cnt_insn, o_cnt_ctrl, o_cnt_mispred;

  logic [31:0] p4_pc_debug;
  logic        p4_insn_vld, p4_ctrl, p4_mispred;
  logic [3:0]  p4_cnt_cycle, p4_cnt_insn, p4_cnt_ctrl, p4_cnt_mispred;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  commit_trace_gen #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc), .i_if_vld(i_if_vld),
    .i_stall(i_stall), .i_flush(i_flush), .i_ex_ctrl(i_ex_ctrl),
    .i_ex_mispred(i_ex_mispred), .i_cnt_clr(i_cnt_clr),
    .o_pc_debug(o_pc_debug), .o_insn_vld(o_insn_vld), .o_ctrl(o_ctrl),
    .o_mispred(o_mispred), .o_cnt_cycle(o_cnt_cycle), .o_cnt_insn(o_cnt_insn),
    .o_cnt_ctrl(o_cnt_ctrl), .o_cnt_mispred(o_cnt_mispred)
  );

  commit_trace_gen #(.RESET_PC(RPC), .CNT_W(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc), .i_if_vld(i_if_vld),
    .i_stall(i_stall), .i_flush(i_flush), .i_ex_ctrl(i_ex_ctrl),
    .i_ex_mispred(i_ex_mispred), .i_cnt_clr(i_cnt_clr),
    .o_pc_debug(p4_pc_debug), .o_insn_vld(p4_insn_vld), .o_ctrl(p4_ctrl),
    .o_mispred(p4_mispred), .o_cnt_cycle(p4_cnt_cycle), .o_cnt_insn(p4_cnt_insn),
    .o_cnt_ctrl(p4_cnt_ctrl), .o_cnt_mispred(p4_cnt_mispred)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit record of both instances.
  task automatic chkw(input string tag, input logic [31:0] pc, input logic vld,
                      input logic ctrl, input logic mis);
    chk({tag, "_pc"},   64'(o_pc_debug), 64'(pc));
    chk({tag, "_vld"},  64'(o_insn_vld), 64'(vld));
    chk({tag, "_ctrl"}, 64'(o_ctrl),     64'(ctrl));
    chk({tag, "_mis"},  64'(o_mispred),  64'(mis));
    chk({tag, "_pc4"},  64'(p4_pc_debug), 64'(pc));
    chk({tag, "_vld4"}, 64'(p4_insn_vld), 64'(vld));
  endtask

  task automatic chkc(input string tag, input logic [31:0] cyc, input logic [31:0] insn,
                      input logic [31:0] ctl, input logic [31:0] mis);
    chk({tag, "_cyc"},  64'(o_cnt_cycle),   64'(cyc));
    chk({tag, "_insn"}, 64'(o_cnt_insn),    64'(insn));
    chk({tag, "_ctrl"}, 64'(o_cnt_ctrl),    64'(ctl));
    chk({tag, "_mis"},  64'(o_cnt_mispred), 64'(mis));
  endtask

  task automatic setin(input logic [31:0] pc, input logic vld, input logic stall,
                       input logic flush, input logic ctrl, input logic mis);
    i_if_pc      = pc;
    i_if_vld     = vld;
    i_stall      = stall;
    i_flush      = flush;
    i_ex_ctrl    = ctrl;
    i_ex_mispred = mis;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset   = 1'b1;
    i_cnt_clr = 1'b0;
    setin(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 i_reset = 1'b0;
    #1;
    chkw("rst", RPC, 1'b0, 1'b0, 1'b0);
    chkc("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chkw("rst_hold", RPC, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b1;

    // Back-to-back fetches; a mispred without ctrl on 0x0 must be ignored.
    setin(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    setin(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chkw("seq_0", 32'h0, 1'b1, 1'b0, 1'b0);
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chkw("seq_4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick();
    chkw("seq_8", 32'h8, 1'b1, 1'b0, 1'b0);
    tick();
    chkw("seq_c", 32'hC, 1'b1, 1'b0, 1'b0);
    chk("seq_insn3", 64'(o_cnt_insn), 64'd3);
    tick();
    chkw("seq_idle", 32'h40, 1'b0, 1'b0, 1'b0);
    chkc("seq_cnt", 32'd8, 32'd4, 32'd0, 32'd0);

    // One stall cycle while 0x14 sits in D; ctrl on the bubble is ignored.
    setin(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chkw("stl_10", 32'h10, 1'b1, 1'b0, 1'b0);
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chkw("stl_bub", 32'h14, 1'b0, 1'b0, 1'b0);
    tick();
    chkw("stl_14", 32'h14, 1'b1, 1'b0, 1'b0);
    chk("stl_insn", 64'(o_cnt_insn), 64'd5);

    // Mispredicted branch at 0x20 flushes 0x24 and 0x28.
    setin(32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h28, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chkw("br_20", 32'h20, 1'b1, 1'b1, 1'b1);
    tick();
    chkw("br_24", 32'h24, 1'b0, 1'b0, 1'b0);
    tick();
    chkw("br_28", 32'h28, 1'b0, 1'b0, 1'b0);
    chkc("br_cnt", 32'd20, 32'd7, 32'd1, 32'd1);
    chk("br_cyc4_sat", 64'(p4_cnt_cycle), 64'hF);
    chk("br_insn4", 64'(p4_cnt_insn), 64'd7);

    // Self-loop at 0x1c, flushed every cycle.
    setin(32'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chkw("loop_a", 32'h1C, 1'b0, 1'b0, 1'b0);
    chk("loop_insn_a", 64'(o_cnt_insn), 64'd7);
    chk("loop_cyc_a", 64'(o_cnt_cycle), 64'd24);
    repeat (2) tick();
    chkw("loop_b", 32'h1C, 1'b0, 1'b0, 1'b0);
    chk("loop_insn_b", 64'(o_cnt_insn), 64'd7);
    chk("loop_cyc_b", 64'(o_cnt_cycle), 64'd26);

    // 20 valid commits: 4-bit insn counter saturates; clear on a commit cycle.
    for (int k = 0; k < 20; k++) begin
      setin(32'h200 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      i_cnt_clr = (k == 18);
      tick();
      if (k == 10) chk("sat_insn4_e", 64'(p4_cnt_insn), 64'hE);
      if (k == 12) begin
        chk("sat_insn4_f", 64'(p4_cnt_insn), 64'hF);
        chk("sat_insn32", 64'(o_cnt_insn), 64'd16);
      end
      if (k == 17) chkw("sat_commit", 32'h238, 1'b1, 1'b0, 1'b0);
      if (k == 18) begin
        chkc("clr", 32'd0, 32'd0, 32'd0, 32'd0);
        chk("clr_cyc4", 64'(p4_cnt_cycle), 64'd0);
        chk("clr_insn4", 64'(p4_cnt_insn), 64'd0);
        chk("clr_ctrl4", 64'(p4_cnt_ctrl), 64'd0);
        chk("clr_mis4", 64'(p4_cnt_mispred), 64'd0);
      end
    end
    i_cnt_clr = 1'b0;
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chkc("post_clr", 32'd5, 32'd5, 32'd0, 32'd0);
    chk("post_clr_insn4", 64'(p4_cnt_insn), 64'd5);

    // Reset mid-stream with four instructions in flight.
    for (int k = 0; k < 4; k++) begin
      setin(32'h300 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chkw("mid_pre", 32'h300, 1'b1, 1'b0, 1'b0);
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 i_reset = 1'b0;
    #1;
    chkw("mid_rst", RPC, 1'b0, 1'b0, 1'b0);
    chkc("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chkw("mid_rst_hold", RPC, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_nostale", 64'(o_insn_vld), 64'd0);
    end
    chk("mid_insn0", 64'(o_cnt_insn), 64'd0);
    chk("mid_cyc4", 64'(o_cnt_cycle), 64'd4);
    setin(32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    setin(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("mid_early", 64'(o_insn_vld), 64'd0);
    tick();
    chkw("mid_first", 32'h400, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_gen.md
Name: commit_trace_gen

Overview:
Producer side of the pipeline's commit-trace interface (o_pc_debug / o_insn_vld / o_ctrl / o_mispred) that the ISA-test scoreboard consumes.
- Shadows the 5-stage pipeline with IF/ID, ID/EX, EX/MEM and MEM/WB tag registers.
- Honours stall and flush, and tags control-flow outcome at EX.
- Emits one commit record per cycle from the WB slot.
- Also keeps on-chip saturating performance counters (cycles, instructions, control ops, mispredicts) so IPC and mispredict rate are available in silicon.

Parameters:
RESET_PC, 32'h0, pc field value loaded into every tag register on reset
CNT_W, 32, width of each performance counter

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_if_pc  in  32  pc of the instruction fetched this cycle
i_if_vld  in  1  fetch slot holds a real instruction
i_stall  in  1  load-use stall: hold IF/ID, inject bubble into ID/EX
i_flush  in  1  EX-resolved redirect: kill IF/ID and ID/EX contents
i_ex_ctrl  in  1  instruction currently in EX is branch/jump
i_ex_mispred  in  1  instruction currently in EX was mispredicted
i_cnt_clr  in  1  synchronous clear of all counters
o_pc_debug  out  32  pc of WB slot
o_insn_vld  out  1  WB slot is a real committed instruction
o_ctrl  out  1  committed instruction is control-flow
o_mispred  out  1  committed instruction was mispredicted
o_cnt_cycle  out  CNT_W  cycles since reset/clear
o_cnt_insn  out  CNT_W  committed instructions
o_cnt_ctrl  out  CNT_W  committed control-flow instructions
o_cnt_mispred  out  CNT_W  committed mispredicts

Behaviour:
- Tag = {vld, pc, ctrl, mispred}. Four tag registers: D (IF/ID), E (ID/EX), M (EX/MEM), W (MEM/WB).
- Reset (i_reset=0, async): all tags vld=0, ctrl=0, mispred=0, pc=RESET_PC. All counters 0. Outputs therefore reset to pc=RESET_PC and 0 everywhere else.
- Per rising edge, priority flush > stall > normal:
  - D: flush -> vld=0, pc=i_if_pc; stall -> hold; else -> {i_if_vld, i_if_pc}, ctrl=mispred=0.
  - E: flush or stall -> copy of D with vld=0 (bubble keeps the source pc); else -> D.
  - M: E, with ctrl = E.vld & i_ex_ctrl and mispred = E.vld & i_ex_ctrl & i_ex_mispred. A mispred without ctrl is ignored.
  - W: M, unconditionally; no stall or flush reaches M/W.
- A flush does not kill the EX instruction that caused it; that instruction proceeds to M carrying its mispred flag.
- Outputs are driven directly from W: o_pc_debug=W.pc, o_insn_vld=W.vld, o_ctrl=W.ctrl, o_mispred=W.mispred. ctrl and mispred are already 0 for bubbles.
- Latency: a fetch in cycle n with no stall or flush commits (outputs valid) in cycle n+4. Each stall cycle adds 1.
- Bubbles carry a pc with vld=0, so a self-loop halt shows as repeated pc with o_insn_vld=0.
- Counters update on the rising edge when i_reset=1:
  - i_cnt_clr=1 -> all counters 0. Clear wins over increment in the same cycle.
  - Otherwise: cycle +1; insn +1 if W.vld; ctrl +1 if W.ctrl; mispred +1 if W.mispred. Counters sample the W tag as it stands this cycle, i.e. the current outputs.
  - Each counter saturates at all-ones and never wraps.
- Reset asserted mid-operation: every in-flight tag is dropped immediately (async). After release, the first commit appears 4 cycles after the first valid fetch.

Test Plan:
- Reset, then fetch pcs 0x0,0x4,0x8,0xC back-to-back, no stall/flush -> o_insn_vld=1 with pc 0x0..0xC on cycles 4..7 after the first fetch; o_cnt_insn=4 at cycle 8.
- Fetch 0x10,0x14 with i_stall=1 for one cycle while 0x14 is in D -> one bubble: o_insn_vld=0 between commits of 0x10 and 0x14; 0x14 commits 5 cycles after fetch.
- Branch at 0x20 in EX with i_ex_ctrl=1, i_ex_mispred=1, i_flush=1; 0x24 and 0x28 younger -> 0x20 commits with o_ctrl=1, o_mispred=1; 0x24 and 0x28 appear with o_insn_vld=0; o_cnt_ctrl=1, o_cnt_mispred=1.
- Self-loop at 0x1c, flushed every cycle -> o_pc_debug=0x1c with o_insn_vld=0 observed; o_cnt_insn stops incrementing while o_cnt_cycle keeps incrementing.
- CNT_W=4, 20 valid commits -> o_cnt_insn saturates at 4'hF. Asserting i_cnt_clr on a commit cycle -> all counters 0 next cycle.
- Drop i_reset low for one cycle mid-stream with 4 instructions in flight -> outputs go to RESET_PC/0 immediately; no stale commits after release.
